lm07_spi_sequencer: RTL and testbench

//  Master-side SPI read sequencer for the LM07/LM70-family temperature sensor.

---
 rtl/lm07_pkg.sv | 15 +
 rtl/lm07_spi_sequencer_if.sv | 24 ++
 rtl/lm07_sck_gen.sv | 42 ++++
 rtl/lm07_spi_sequencer.sv | 135 +++++++++++++
 tb/tb_lm07_spi_sequencer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lm07_pkg.sv
// Shared types and constants for the LM07/LM70 SPI read sequencer.
package lm07_pkg;

    localparam int unsigned LM07_NBITS = 16;
    localparam int unsigned LM07_MSB_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } lm07_state_e;

endpackage

// File: rtl/lm07_spi_sequencer_if.sv
// Host-side request/result bundle of the LM07 sequencer.
interface lm07_spi_sequencer_if import lm07_pkg::*; #(
    parameter int unsigned NBITS = LM07_NBITS
) ();

    logic                  ena;
    logic                  auto_en;
    logic                  start;
    logic                  busy_o;
    logic [NBITS-1:0]      data_o;
    logic [LM07_MSB_W-1:0] msb_o;
    logic                  valid_o;

    modport master (
        output ena, auto_en, start,
        input  busy_o, data_o, msb_o, valid_o
    );

    modport slave (
        input  ena, auto_en, start,
        output busy_o, data_o, msb_o, valid_o
    );

endinterface

// File: rtl/lm07_sck_gen.sv
// SCK half-period generator: toggles sck every CLK_DIV clk cycles while run is high.
module lm07_sck_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic last,
    output logic sck,
    output logic rise_tick,
    output logic fall_tick,
    output logic half_tick
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] hcnt;

    // Counter idles at its terminal value so the first run cycle produces a rise.
    assign half_tick = run & (hcnt == CW'(CLK_DIV - 1));
    assign rise_tick = half_tick & ~sck & ~last;
    assign fall_tick = half_tick & sck;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= '0;
            sck  <= 1'b0;
        end else if (!run) begin
            hcnt <= CW'(CLK_DIV - 1);
            sck  <= 1'b0;
        end else if (half_tick) begin
            hcnt <= '0;
            if (rise_tick)
                sck <= 1'b1;
            else if (fall_tick)
                sck <= 1'b0;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

endmodule

// File: rtl/lm07_spi_sequencer.sv
// Master-side LM07/LM70 read sequencer: CS/SCK framing, 16-bit capture, one-shot
// and periodic frame scheduling.
module lm07_spi_sequencer import lm07_pkg::*; #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned NBITS    = LM07_NBITS,
    parameter int unsigned CS_SETUP = 1,
    parameter int unsigned CS_HOLD  = 1,
    parameter int unsigned CS_GAP   = 4,
    parameter int unsigned PERIOD   = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lm07_spi_sequencer_if.slave  host,
    input  logic                 sio_i,
    output logic                 cs_n_o,
    output logic                 sck_o
);

    localparam int unsigned CYC_MAX = (CS_GAP > CS_SETUP) ?
                                      ((CS_GAP > CS_HOLD) ? CS_GAP : CS_HOLD) :
                                      ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
    localparam int unsigned CYC_W = $clog2(CYC_MAX + 1);
    localparam int unsigned BIT_W = $clog2(NBITS + 1);
    localparam int unsigned PER_W = $clog2(PERIOD + 1);

    lm07_state_e      state, state_d;
    logic [CYC_W-1:0] cyc_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [NBITS-1:0] shift_reg;
    logic [PER_W-1:0] per_cnt;
    logic             pending;

    logic sck, rise_tick, fall_tick, half_tick;
    logic sck_run, bit_done, auto_tick, launch;

    assign bit_done  = (bit_cnt == BIT_W'(NBITS));
    assign auto_tick = host.ena & host.auto_en & (per_cnt == PER_W'(PERIOD - 1));
    assign launch    = (state == IDLE) & host.ena & (host.start | pending | auto_tick);
    // SCK starts on the edge that leaves SETUP so the first rise lands CS_SETUP cycles after CS falls.
    assign sck_run   = (state == SHIFT) |
                       ((state == SETUP) & (cyc_cnt == CYC_W'(CS_SETUP - 1)));

    lm07_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (sck_run),
        .last      (bit_done),
        .sck       (sck),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .half_tick (half_tick)
    );

    assign sck_o       = sck;
    assign host.msb_o  = host.data_o[NBITS-1 -: LM07_MSB_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:  if (launch) state_d = SETUP;
            SETUP: if (cyc_cnt == CYC_W'(CS_SETUP - 1)) state_d = SHIFT;
            SHIFT: if (bit_done && half_tick && !sck) state_d = HOLD;
            HOLD:  if (cyc_cnt == CYC_W'(CS_HOLD - 1)) state_d = GAP;
            GAP:   if (cyc_cnt == CYC_W'(CS_GAP - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            if (state_d != state)
                cyc_cnt <= '0;
            else if (state inside {SETUP, HOLD, GAP})
                cyc_cnt <= cyc_cnt + 1'b1;

            if (launch)
                bit_cnt <= '0;
            else if (rise_tick)
                bit_cnt <= bit_cnt + 1'b1;

            // Sample on the edge that drops SCK; the sensor has not shifted yet.
            if (fall_tick)
                shift_reg <= {shift_reg[NBITS-2:0], sio_i};
        end
    end

    // Period counter: preloaded while auto is off so enabling auto reads immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt <= '0;
            pending <= 1'b0;
        end else if (host.ena) begin
            if (!host.auto_en)
                per_cnt <= PER_W'(PERIOD - 1);
            else if (launch || auto_tick)
                per_cnt <= '0;
            else
                per_cnt <= per_cnt + 1'b1;

            if (launch)
                pending <= 1'b0;
            else if ((host.start || auto_tick) && (state != IDLE))
                pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_n_o       <= 1'b1;
            host.busy_o  <= 1'b0;
            host.valid_o <= 1'b0;
            host.data_o  <= '0;
        end else begin
            cs_n_o       <= !(state_d inside {SETUP, SHIFT, HOLD});
            host.busy_o  <= (state_d != IDLE);
            host.valid_o <= (state == HOLD) && (state_d == GAP);
            if ((state == HOLD) && (state_d == GAP))
                host.data_o <= shift_reg;
        end
    end

endmodule

// File: tb/tb_lm07_spi_sequencer.sv
// Scoreboard bench for lm07_spi_sequencer with a behavioural LM07 sensor on SIO.
`timescale 1ns/1ps
module tb_lm07_spi_sequencer;
    import lm07_pkg::*;

    localparam int unsigned NB = 16;

    typedef struct packed {
        logic [15:0] data;
        logic [7:0]  msb;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic sio_i, cs_n_o, sck_o;

    always #5 clk = ~clk;

    lm07_spi_sequencer_if #(.NBITS(NB)) host ();

    lm07_spi_sequencer #(
        .CLK_DIV  (2),
        .NBITS    (NB),
        .CS_SETUP (1),
        .CS_HOLD  (1),
        .CS_GAP   (4),
        .PERIOD   (200)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .host   (host),
        .sio_i  (sio_i),
        .cs_n_o (cs_n_o),
        .sck_o  (sck_o)
    );

    // Sensor: reloads while CS is high, shifts out MSB first on SCK fall.
    logic [15:0] sens_word;
    logic [15:0] sens_sr;
    always @(posedge cs_n_o or negedge sck_o or sens_word) begin
        if (cs_n_o)
            sens_sr = sens_word;
        else if (!sck_o)
            sens_sr = {sens_sr[14:0], 1'b0};
    end
    assign sio_i = sens_sr[15];

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    exp_t        exp_q[$];
    int unsigned launch_t[$];
    int          cyc = 0;
    int unsigned low_cnt = 0, rises = 0, vcount = 0;
    int unsigned abort_req = 0, abort_done = 0;
    int          last_rise_cyc = -1000;
    logic        prev_cs = 1'b1, prev_sck = 1'b0, prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: frame timing and scoreboard pops on valid_o.
    always @(negedge clk) begin
        exp_t e;
        if (prev_cs && !cs_n_o) begin
            launch_t.push_back(cyc);
            check("cs_gap_ge4", 32'((cyc - last_rise_cyc) >= 4), 32'd1);
            low_cnt = 0;
            rises   = 0;
        end
        if (!cs_n_o) low_cnt++;
        if (!prev_sck && sck_o) rises++;
        if (!prev_cs && cs_n_o) begin
            if (abort_req == abort_done) begin
                check("cs_low_cycles", low_cnt, 32'd66);
                check("sck_rises", rises, 32'd16);
            end
            abort_done    = abort_req;
            last_rise_cyc = cyc;
        end
        if (host.valid_o) begin
            vcount++;
            check("valid_one_cycle", 32'(prev_valid), 32'd0);
            check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("data_o", 32'(host.data_o), 32'(e.data));
                check("msb_o", 32'(host.msb_o), 32'(e.msb));
            end
        end
        prev_cs    = cs_n_o;
        prev_sck   = sck_o;
        prev_valid = host.valid_o;
    end

    task automatic pulse_start();
        @(negedge clk);
        host.start = 1'b1;
        @(negedge clk);
        host.start = 1'b0;
    endtask

    task automatic wait_valids(input int unsigned target, input int unsigned budget, input string name);
        int unsigned n = 0;
        while (vcount < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid_seen"}, 32'(vcount >= target), 32'd1);
    endtask

    task automatic wait_rises(input int unsigned k, input string name);
        int unsigned n = 0;
        while (!(!cs_n_o && rises >= k) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, "_sck_reached"}, 32'(!cs_n_o && rises >= k), 32'd1);
    endtask

    initial begin
        int unsigned n0, l0;
        host.ena     = 1'b1;
        host.auto_en = 1'b0;
        host.start   = 1'b0;
        #1;
        rst_n     = 1'b0;
        sens_word = 16'h0B9F;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_cs_n", 32'(cs_n_o), 32'd1);
        check("rst_sck", 32'(sck_o), 32'd0);
        check("rst_busy", 32'(host.busy_o), 32'd0);
        check("rst_valid", 32'(host.valid_o), 32'd0);
        check("rst_data", 32'(host.data_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single read
        n0 = vcount;
        l0 = launch_t.size();
        exp_q.push_back('{16'h0B9F, 8'h0B});
        pulse_start();
        check("single_busy", 32'(host.busy_o), 32'd1);
        wait_valids(n0 + 1, 200, "single");
        repeat (10) @(negedge clk);
        check("single_launches", launch_t.size() - l0, 32'd1);
        check("single_idle_busy", 32'(host.busy_o), 32'd0);
        check("single_hold_data", 32'(host.data_o), 32'h0B9F);

        // Auto mode, PERIOD=200
        n0 = vcount;
        l0 = launch_t.size();
        repeat (5) exp_q.push_back('{16'h0B9F, 8'h0B});
        @(negedge clk);
        host.auto_en = 1'b1;
        repeat (995) @(negedge clk);
        host.auto_en = 1'b0;
        wait_valids(n0 + 5, 100, "auto");
        check("auto_launches", launch_t.size() - l0, 32'd5);
        if (launch_t.size() >= l0 + 5)
            for (int i = 1; i < 5; i++)
                check("auto_spacing", launch_t[l0 + i] - launch_t[l0 + i - 1], 32'd200);
        repeat (80) @(negedge clk);

        // Coalesce: three starts during SHIFT give exactly one extra frame
        n0 = vcount;
        l0 = launch_t.size();
        exp_q.push_back('{16'h0B9F, 8'h0B});
        pulse_start();
        wait_rises(2, "coalesce");
        repeat (3) begin
            pulse_start();
            repeat (3) @(negedge clk);
        end
        exp_q.push_back('{16'h0B9F, 8'h0B});
        wait_valids(n0 + 2, 400, "coalesce");
        repeat (150) @(negedge clk);
        check("coalesce_launches", launch_t.size() - l0, 32'd2);

        // Abort with async reset at the 8th SCK rise
        pulse_start();
        wait_rises(8, "abort");
        abort_req++;
        #1 rst_n = 1'b0;
        #1;
        check("abort_cs_n", 32'(cs_n_o), 32'd1);
        check("abort_sck", 32'(sck_o), 32'd0);
        check("abort_busy", 32'(host.busy_o), 32'd0);
        check("abort_data_cleared", 32'(host.data_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n0 = vcount;
        exp_q.push_back('{16'h0B9F, 8'h0B});
        pulse_start();
        wait_valids(n0 + 1, 200, "post_abort");
        repeat (10) @(negedge clk);

        // Pattern 241F
        sens_word = 16'h241F;
        n0 = vcount;
        exp_q.push_back('{16'h241F, 8'h24});
        pulse_start();
        wait_valids(n0 + 1, 200, "pat241f");
        repeat (10) @(negedge clk);

        // Pattern 8001 with ena dropped mid-frame
        sens_word = 16'h8001;
        n0 = vcount;
        l0 = launch_t.size();
        exp_q.push_back('{16'h8001, 8'h80});
        pulse_start();
        wait_rises(4, "ena_low");
        host.ena = 1'b0;
        pulse_start();
        wait_valids(n0 + 1, 200, "ena_low");
        repeat (100) @(negedge clk);
        check("ena_low_launches", launch_t.size() - l0, 32'd1);
        check("ena_low_busy", 32'(host.busy_o), 32'd0);
        check("ena_low_cs_n", 32'(cs_n_o), 32'd1);
        host.ena = 1'b1;
        repeat (100) @(negedge clk);
        check("ena_restore_launches", launch_t.size() - l0, 32'd1);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
